// File: rtl/ten_eth_port_lookup_if.sv
// Request/result bundle between the ten_eth rx ports and the port lookup block.
// Port p owns slice [48p+47:48p] of i_check_mac, [4p+3:4p] of i_check_id and bit p of the strobes.
interface ten_eth_port_lookup_if #(
  parameter int P_PORT_NUM = 2
);
  logic [48*P_PORT_NUM-1:0] i_check_mac;
  logic [4*P_PORT_NUM-1:0]  i_check_id;
  logic [P_PORT_NUM-1:0]    i_check_valid;
  logic [2:0]               i_cur_connect_tor;
  logic [2:0]               o_outport;
  logic [3:0]               o_check_id;
  logic [1:0]               o_seek_flag;
  logic [P_PORT_NUM-1:0]    o_result_valid;

  modport master (
    output i_check_mac, i_check_id, i_check_valid, i_cur_connect_tor,
    input  o_outport, o_check_id, o_seek_flag, o_result_valid
  );

  modport slave (
    input  i_check_mac, i_check_id, i_check_valid, i_cur_connect_tor,
    output o_outport, o_check_id, o_seek_flag, o_result_valid
  );
endinterface

// File: rtl/ten_eth_port_lookup.sv
// Outport lookup for the ten_eth rx ports: 2-deep request FIFO per port, round-robin arbiter,
// registered MAC decode. Define LOOKUP_STATS_EN to build the o_stat_* counters (else tied to 0).
module ten_eth_port_lookup #(
  parameter int          P_PORT_NUM    = 2,
  parameter logic [31:0] P_MAC_HEAD    = 32'h8DBC5C4A,
  parameter logic [2:0]  P_MY_TOR_ID   = 3'd0,
  parameter int          P_LOCAL_PORTS = 2,
  parameter logic [2:0]  P_UPLINK_PORT = 3'd7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ten_eth_port_lookup_if.slave  bus,
  output logic [15:0]           o_stat_overflow,
  output logic [15:0]           o_stat_local,
  output logic [15:0]           o_stat_uplink,
  output logic [15:0]           o_stat_buffer,
  output logic [15:0]           o_stat_drop
);
  localparam int PW = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1;

  logic [47:0]           r_fifo_mac [P_PORT_NUM][2];
  logic [3:0]            r_fifo_id  [P_PORT_NUM][2];
  logic [1:0]            r_count    [P_PORT_NUM];
  logic [P_PORT_NUM-1:0] r_rd_sel;
  logic [P_PORT_NUM-1:0] r_wr_sel;
  logic [PW-1:0]         r_ptr;
  logic                  r_s1_valid;
  logic [47:0]           r_s1_mac;
  logic [3:0]            r_s1_id;
  logic [PW-1:0]         r_s1_port;

  logic [P_PORT_NUM-1:0] w_nonempty;
  logic [P_PORT_NUM-1:0] w_pop;
  logic [P_PORT_NUM-1:0] w_push;
  logic                  w_grant_valid;
  logic [PW-1:0]         w_grant_idx;
  logic [47:0]           w_head_mac;
  logic [3:0]            w_head_id;
  logic [7:0]            w_tor;
  logic [7:0]            w_prt;
  logic [2:0]            w_outport;
  logic [1:0]            w_flag;

  always_comb begin
    for (int p = 0; p < P_PORT_NUM; p++)
      w_nonempty[p] = (r_count[p] != 2'd0);
  end

  // Lowest non-empty index at or above r_ptr wins; otherwise lowest non-empty below it.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int j = P_PORT_NUM - 1; j >= 0; j--) begin
      if (w_nonempty[j] && (j < int'(r_ptr))) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = PW'(j);
      end
    end
    for (int j = P_PORT_NUM - 1; j >= 0; j--) begin
      if (w_nonempty[j] && (j >= int'(r_ptr))) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = PW'(j);
      end
    end
  end

  // A full FIFO still accepts a write when its head leaves on the same edge.
  always_comb begin
    for (int p = 0; p < P_PORT_NUM; p++) begin
      w_pop[p]  = w_grant_valid && (w_grant_idx == PW'(p));
      w_push[p] = bus.i_check_valid[p] && ((r_count[p] != 2'd2) || w_pop[p]);
    end
  end

  always_comb begin
    w_head_mac = '0;
    w_head_id  = '0;
    for (int p = 0; p < P_PORT_NUM; p++) begin
      if (w_pop[p]) begin
        w_head_mac = r_fifo_mac[p][r_rd_sel[p]];
        w_head_id  = r_fifo_id[p][r_rd_sel[p]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < P_PORT_NUM; p++) begin
      if (w_push[p]) begin
        r_fifo_mac[p][r_wr_sel[p]] <= bus.i_check_mac[48*p +: 48];
        r_fifo_id[p][r_wr_sel[p]]  <= bus.i_check_id[4*p +: 4];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < P_PORT_NUM; p++)
        r_count[p] <= 2'd0;
      r_rd_sel <= '0;
      r_wr_sel <= '0;
    end else begin
      for (int p = 0; p < P_PORT_NUM; p++)
        r_count[p] <= r_count[p] + {1'b0, w_push[p]} - {1'b0, w_pop[p]};
      r_wr_sel <= r_wr_sel ^ w_push;
      r_rd_sel <= r_rd_sel ^ w_pop;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_mac   <= '0;
      r_s1_id    <= '0;
      r_s1_port  <= '0;
    end else begin
      r_s1_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_s1_mac  <= w_head_mac;
        r_s1_id   <= w_head_id;
        r_s1_port <= w_grant_idx;
        r_ptr     <= (int'(w_grant_idx) == P_PORT_NUM - 1) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign w_tor = r_s1_mac[15:8];
  assign w_prt = r_s1_mac[7:0];

  // Local ToR takes priority over the uplink match; unknown head or bad ToR drops.
  always_comb begin
    w_flag    = 2'b11;
    w_outport = 3'd0;
    if ((r_s1_mac[47:16] == P_MAC_HEAD) && (w_tor < 8'd8)) begin
      if (w_tor[2:0] == P_MY_TOR_ID) begin
        if ((w_prt >= 8'd1) && (int'(w_prt) <= P_LOCAL_PORTS)) begin
          w_flag    = 2'b00;
          w_outport = 3'(w_prt - 8'd1);
        end
      end else if (w_tor[2:0] == bus.i_cur_connect_tor) begin
        w_flag    = 2'b01;
        w_outport = P_UPLINK_PORT;
      end else begin
        w_flag    = 2'b10;
        w_outport = w_tor[2:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_outport      <= '0;
      bus.o_check_id     <= '0;
      bus.o_seek_flag    <= '0;
      bus.o_result_valid <= '0;
    end else begin
      for (int p = 0; p < P_PORT_NUM; p++)
        bus.o_result_valid[p] <= r_s1_valid && (r_s1_port == PW'(p));
      if (r_s1_valid) begin
        bus.o_outport   <= w_outport;
        bus.o_check_id  <= r_s1_id;
        bus.o_seek_flag <= w_flag;
      end
    end
  end

`ifdef LOOKUP_STATS_EN
  logic [15:0]           r_stat_overflow;
  logic [15:0]           r_stat_local;
  logic [15:0]           r_stat_uplink;
  logic [15:0]           r_stat_buffer;
  logic [15:0]           r_stat_drop;
  logic [P_PORT_NUM-1:0] w_drop;
  logic [16:0]           w_ovf_sum;

  function automatic logic [15:0] f_sat_inc(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  // Several ports can lose a write on the same edge, so overflow adds the whole count.
  always_comb begin
    w_drop    = bus.i_check_valid & ~w_push;
    w_ovf_sum = {1'b0, r_stat_overflow} + 17'($countones(w_drop));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_overflow <= '0;
      r_stat_local    <= '0;
      r_stat_uplink   <= '0;
      r_stat_buffer   <= '0;
      r_stat_drop     <= '0;
    end else begin
      r_stat_overflow <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
      if (r_s1_valid) begin
        unique case (w_flag)
          2'b00:   r_stat_local  <= f_sat_inc(r_stat_local);
          2'b01:   r_stat_uplink <= f_sat_inc(r_stat_uplink);
          2'b10:   r_stat_buffer <= f_sat_inc(r_stat_buffer);
          default: r_stat_drop   <= f_sat_inc(r_stat_drop);
        endcase
      end
    end
  end

  assign o_stat_overflow = r_stat_overflow;
  assign o_stat_local    = r_stat_local;
  assign o_stat_uplink   = r_stat_uplink;
  assign o_stat_buffer   = r_stat_buffer;
  assign o_stat_drop     = r_stat_drop;
`else
  assign o_stat_overflow = 16'd0;
  assign o_stat_local    = 16'd0;
  assign o_stat_uplink   = 16'd0;
  assign o_stat_buffer   = 16'd0;
  assign o_stat_drop     = 16'd0;
`endif
endmodule

// File: tb/tb_ten_eth_port_lookup.sv
// Bench for ten_eth_port_lookup: a queue-based reference model is compared with the DUT on
// every falling edge, and directed vectors carry hand-computed literal expectations.
module tb_ten_eth_port_lookup;
  localparam int          P           = 2;
  localparam logic [31:0] MAC_HEAD    = 32'h8DBC5C4A;
  localparam int          MY_TOR      = 0;
  localparam int          LOCAL_PORTS = 2;
  localparam logic [2:0]  UPLINK      = 3'd7;
`ifdef LOOKUP_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  port;
    logic [47:0] mac;
    logic [3:0]  id;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] statOvf;
  logic [15:0] statLocal;
  logic [15:0] statUplink;
  logic [15:0] statBuffer;
  logic [15:0] statDrop;
  int          checks = 0;
  int          errors = 0;

  mreq_t       mq[$];
  int          mptr = 0;
  bit          ms1v = 1'b0;
  mreq_t       ms1 = '0;
  logic [1:0]  expRv = '0;
  logic [2:0]  expOut = '0;
  logic [1:0]  expFlag = '0;
  logic [3:0]  expId = '0;
  int          cntOvf = 0;
  int          cntLocal = 0;
  int          cntUplink = 0;
  int          cntBuffer = 0;
  int          cntDrop = 0;

  ten_eth_port_lookup_if #(.P_PORT_NUM(P)) bus ();

  ten_eth_port_lookup #(
    .P_PORT_NUM   (P),
    .P_MAC_HEAD   (MAC_HEAD),
    .P_MY_TOR_ID  (3'd0),
    .P_LOCAL_PORTS(LOCAL_PORTS),
    .P_UPLINK_PORT(UPLINK)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .bus            (bus.slave),
    .o_stat_overflow(statOvf),
    .o_stat_local   (statLocal),
    .o_stat_uplink  (statUplink),
    .o_stat_buffer  (statBuffer),
    .o_stat_drop    (statDrop)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Destination rules applied straight to the MAC fields.
  task automatic modelDecode(input logic [47:0] mac, input logic [2:0] cur,
                             output logic [2:0] out, output logic [1:0] flag);
    int tor;
    int prt;
    tor  = int'(mac[15:8]);
    prt  = int'(mac[7:0]);
    out  = 3'd0;
    flag = 2'b11;
    if (mac[47:16] == MAC_HEAD && tor <= 7) begin
      if (tor == MY_TOR) begin
        if (prt >= 1 && prt <= LOCAL_PORTS) begin
          flag = 2'b00;
          out  = 3'(prt - 1);
        end
      end else if (tor == int'(cur)) begin
        flag = 2'b01;
        out  = UPLINK;
      end else begin
        flag = 2'b10;
        out  = 3'(tor);
      end
    end
  endtask

  function automatic int pending(input int p);
    int n = 0;
    foreach (mq[i]) if (int'(mq[i].port) == p) n++;
    return n;
  endfunction

  task automatic modelReset();
    mq.delete();
    mptr = 0; ms1v = 1'b0;
    expRv = '0; expOut = '0; expFlag = '0; expId = '0;
    cntOvf = 0; cntLocal = 0; cntUplink = 0; cntBuffer = 0; cntDrop = 0;
  endtask

  task automatic modelStep();
    int g;
    logic [2:0] o;
    logic [1:0] f;
    if (ms1v) begin
      modelDecode(ms1.mac, bus.i_cur_connect_tor, o, f);
      expRv = 2'(1 << ms1.port);
      expOut = o; expFlag = f; expId = ms1.id;
      case (f)
        2'b00:   if (cntLocal  < 65535) cntLocal++;
        2'b01:   if (cntUplink < 65535) cntUplink++;
        2'b10:   if (cntBuffer < 65535) cntBuffer++;
        default: if (cntDrop   < 65535) cntDrop++;
      endcase
    end else begin
      expRv = '0;
    end
    g = -1;
    for (int k = 0; k < P; k++) begin
      int p;
      p = (mptr + k) % P;
      if (g < 0 && pending(p) > 0) g = p;
    end
    ms1v = 1'b0;
    if (g >= 0) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (int'(mq[i].port) == g) begin
          ms1 = mq[i];
          mq.delete(i);
          break;
        end
      end
      ms1v = 1'b1;
      mptr = (g + 1) % P;
    end
    for (int p = 0; p < P; p++) begin
      if (bus.i_check_valid[p]) begin
        if (pending(p) < 2)
          mq.push_back('{port: 3'(p), mac: bus.i_check_mac[48*p +: 48], id: bus.i_check_id[4*p +: 4]});
        else if (cntOvf < 65535)
          cntOvf++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else modelStep();
    end
  end

  // Every falling edge: DUT against the model, including held data and stat counters.
  initial begin
    forever begin
      @(negedge clk);
      checkEq("result_valid", int'(bus.o_result_valid), int'(expRv));
      checkEq("outport", int'(bus.o_outport), int'(expOut));
      checkEq("seek_flag", int'(bus.o_seek_flag), int'(expFlag));
      checkEq("check_id", int'(bus.o_check_id), int'(expId));
      checkEq("stat_overflow", int'(statOvf), STATS_ON ? cntOvf : 0);
      checkEq("stat_local", int'(statLocal), STATS_ON ? cntLocal : 0);
      checkEq("stat_uplink", int'(statUplink), STATS_ON ? cntUplink : 0);
      checkEq("stat_buffer", int'(statBuffer), STATS_ON ? cntBuffer : 0);
      checkEq("stat_drop", int'(statDrop), STATS_ON ? cntDrop : 0);
    end
  end

  task automatic applyStimulus(input int port, input logic [47:0] mac, input logic [3:0] id);
    bus.i_check_mac[48*port +: 48] = mac;
    bus.i_check_id[4*port +: 4]    = id;
    bus.i_check_valid[port]        = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    bus.i_check_valid = '0;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] rv, input logic [2:0] out,
                             input logic [1:0] flag, input logic [3:0] id);
    checkEq({name, ".valid"}, int'(bus.o_result_valid), int'(rv));
    checkEq({name, ".outport"}, int'(bus.o_outport), int'(out));
    checkEq({name, ".flag"}, int'(bus.o_seek_flag), int'(flag));
    checkEq({name, ".id"}, int'(bus.o_check_id), int'(id));
  endtask

  initial begin
    bus.i_check_mac = '0;
    bus.i_check_id = '0;
    bus.i_check_valid = '0;
    bus.i_cur_connect_tor = 3'd0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset", 2'b00, 3'd0, 2'b00, 4'd0);

    $display("[TB] local destination");
    applyStimulus(0, 48'h8DBC5C4A_0002, 4'd3);
    repeat (3) step();
    checkOutput("t1", 2'b01, 3'd1, 2'b00, 4'd3);
    step();
    checkOutput("t1_hold", 2'b00, 3'd1, 2'b00, 4'd3);

    $display("[TB] uplink and buffer");
    bus.i_cur_connect_tor = 3'd5;
    applyStimulus(0, 48'h8DBC5C4A_0501, 4'd4);
    repeat (3) step();
    checkOutput("t2_uplink", 2'b01, 3'd7, 2'b01, 4'd4);
    bus.i_cur_connect_tor = 3'd2;
    applyStimulus(0, 48'h8DBC5C4A_0501, 4'd5);
    repeat (3) step();
    checkOutput("t2_buffer", 2'b01, 3'd5, 2'b10, 4'd5);

    $display("[TB] drop cases");
    applyStimulus(0, 48'h1122_3344_5566, 4'd6);
    repeat (3) step();
    checkOutput("t3_head", 2'b01, 3'd0, 2'b11, 4'd6);
    applyStimulus(1, 48'h8DBC5C4A_0000, 4'd7);
    repeat (3) step();
    checkOutput("t3_port0", 2'b10, 3'd0, 2'b11, 4'd7);
    checkEq("t3_stat_drop", int'(statDrop), STATS_ON ? 2 : 0);
    checkEq("t3_stat_local", int'(statLocal), STATS_ON ? 1 : 0);

    $display("[TB] simultaneous requests");
    applyStimulus(0, 48'h8DBC5C4A_0001, 4'd8);
    applyStimulus(1, 48'h8DBC5C4A_0301, 4'd9);
    repeat (3) step();
    checkOutput("t4_first", 2'b01, 3'd0, 2'b00, 4'd8);
    step();
    checkOutput("t4_second", 2'b10, 3'd3, 2'b10, 4'd9);
    step();
    checkOutput("t4_hold", 2'b00, 3'd3, 2'b10, 4'd9);
    repeat (5) step();
    applyStimulus(0, 48'h8DBC5C4A_0002, 4'd10);
    applyStimulus(1, 48'h8DBC5C4A_0501, 4'd11);
    repeat (6) step();

    $display("[TB] sustained load");
    for (int c = 0; c < 8; c++) begin
      if (c < 3) applyStimulus(0, 48'h8DBC5C4A_0002, 4'(c));
      if (c % 2 == 0) applyStimulus(1, 48'h8DBC5C4A_0401, 4'(8 + c));
      step();
    end
    repeat (6) step();
    checkEq("t5_no_overflow", int'(statOvf), 0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 48'h8DBC5C4A_0001, 4'(c));
      applyStimulus(1, 48'h8DBC5C4A_0601, 4'(8 + c));
      step();
    end
    repeat (10) step();
    checkEq("t5_overflow", int'(statOvf), STATS_ON ? 1 : 0);

    $display("[TB] reset with requests queued");
    applyStimulus(0, 48'h8DBC5C4A_0001, 4'd13);
    applyStimulus(1, 48'h8DBC5C4A_0002, 4'd14);
    step();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      checkOutput("t6_cleared", 2'b00, 3'd0, 2'b00, 4'd0);
      step();
    end
    applyStimulus(1, 48'h8DBC5C4A_0002, 4'd12);
    repeat (3) step();
    checkOutput("t6_after", 2'b10, 3'd1, 2'b00, 4'd12);
    checkEq("t6_stat_local", int'(statLocal), STATS_ON ? 1 : 0);
    repeat (2) step();

    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
